ahb_rsp_mux_p: RTL and testbench

AHB_RSP_MUX_P -- requirements
Module: ahb_rsp_mux_p

---
 rtl/ahb_rsp_mux_p_if.sv | 25 ++
 rtl/ahb_rsp_mux_p.sv | 127 ++++++++++++
 tb/tb_ahb_rsp_mux_p.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_rsp_mux_p_if.sv
// Bus bundle for the AHB response multiplexer: decoder selects, slave responses and the muxed master response.
// "slave" is the multiplexer's view; "master" is the surrounding system that drives it.
interface ahb_rsp_mux_p_if #(
  parameter int NSLV = 5,
  parameter int DW   = 32
);
  logic [NSLV-1:0]    HSEL;
  logic [1:0]         HTRANS;
  logic [NSLV*DW-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADY_S;
  logic [NSLV*2-1:0]  HRESP_S;
  logic [DW-1:0]      HRDATAm;
  logic               HREADYm;
  logic [1:0]         HRESPm;

  modport master (
    output HSEL, HTRANS, HRDATA_S, HREADY_S, HRESP_S,
    input  HRDATAm, HREADYm, HRESPm
  );

  modport slave (
    input  HSEL, HTRANS, HRDATA_S, HREADY_S, HRESP_S,
    output HRDATAm, HREADYm, HRESPm
  );
endinterface

// File: rtl/ahb_rsp_mux_p.sv
// AHB-Lite data-phase response multiplexer with an optional two-cycle ERROR default slave.
// Define AHB_RSP_MUX_DEFSLV_EN to build the default slave FSM and ERR_CNT; otherwise ERR_CNT is 0.
module ahb_rsp_mux_p #(
  parameter int NSLV = 5,
  parameter int DW   = 32,
  parameter int ECW  = 8
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_rsp_mux_p_if.slave bus,
  output logic [ECW-1:0] ERR_CNT
);
  logic [NSLV-1:0]         dsel_reg;
  logic [NSLV-1:0]         dsel_next;
  logic [NSLV-1:0][DW-1:0] rdata_masked;
  logic [NSLV-1:0][1:0]    resp_masked;
  logic [DW-1:0]           sel_rdata;
  logic [1:0]              sel_resp;
  logic                    sel_ready;
  logic                    def_ready;
  logic [1:0]              def_resp;
  logic                    hready_m;
  logic                    unused_bits;

  // Lowest-index select wins: isolate the least-significant set bit.
  assign dsel_next = bus.HSEL & (~bus.HSEL + NSLV'(1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_reg <= '0;
    end else if (hready_m) begin
      dsel_reg <= dsel_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slv
      assign rdata_masked[gi] = dsel_reg[gi] ? bus.HRDATA_S[gi*DW +: DW] : '0;
      assign resp_masked[gi]  = dsel_reg[gi] ? bus.HRESP_S[gi*2 +: 2] : 2'b00;
    end
  endgenerate

  // DSEL is one-hot or zero, so an OR-reduction of the masked lanes is the mux.
  always_comb begin
    sel_rdata = '0;
    sel_resp  = 2'b00;
    for (int i = 0; i < NSLV; i++) begin
      sel_rdata = sel_rdata | rdata_masked[i];
      sel_resp  = sel_resp | resp_masked[i];
    end
  end

  assign sel_ready = |(dsel_reg & bus.HREADY_S);

`ifdef AHB_RSP_MUX_DEFSLV_EN
  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ERR1 = 2'b01,
    D_ERR2 = 2'b10
  } dstate_t;

  dstate_t        dstate_reg;
  logic           dact_reg;
  logic           def_ready_reg;
  logic           def_err_reg;
  logic [ECW-1:0] err_cnt_reg;
  logic           unmapped;

  assign unmapped    = (bus.HSEL == '0) && bus.HTRANS[1];
  assign unused_bits = bus.HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dstate_reg    <= D_IDLE;
      dact_reg      <= 1'b0;
      def_ready_reg <= 1'b1;
      def_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      if (hready_m) begin
        dact_reg <= unmapped;
      end
      case (dstate_reg)
        D_IDLE, D_ERR2: begin
          if (hready_m && unmapped) begin
            dstate_reg    <= D_ERR1;
            def_ready_reg <= 1'b0;
            def_err_reg   <= 1'b1;
            if (err_cnt_reg != '1) begin
              err_cnt_reg <= err_cnt_reg + ECW'(1);
            end
          end else if (hready_m) begin
            dstate_reg    <= D_IDLE;
            def_ready_reg <= 1'b1;
            def_err_reg   <= 1'b0;
          end
        end
        D_ERR1: begin
          dstate_reg    <= D_ERR2;
          def_ready_reg <= 1'b1;
          def_err_reg   <= 1'b1;
        end
        default: begin
          dstate_reg    <= D_IDLE;
          def_ready_reg <= 1'b1;
          def_err_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign def_ready = dact_reg ? def_ready_reg : 1'b1;
  assign def_resp  = dact_reg ? {1'b0, def_err_reg} : 2'b00;
  assign ERR_CNT   = err_cnt_reg;
`else
  assign unused_bits = ^bus.HTRANS;
  assign def_ready   = 1'b1;
  assign def_resp    = 2'b00;
  assign ERR_CNT     = '0;
`endif

  assign hready_m    = (dsel_reg != '0) ? sel_ready : def_ready;
  assign bus.HREADYm = hready_m;
  assign bus.HRESPm  = (dsel_reg != '0) ? sel_resp : def_resp;
  assign bus.HRDATAm = sel_rdata;
endmodule

// File: tb/tb_ahb_rsp_mux_p.sv
// Self-checking bench for ahb_rsp_mux_p: vector table, hand-written corner sequences and a random run
// against a transfer-level reference model. Adapts its expectations to AHB_RSP_MUX_DEFSLV_EN.
`timescale 1ns/1ps
module tb_ahb_rsp_mux_p;
  localparam int NA  = 5;
  localparam int DWA = 32;
  localparam int NB  = 16;
  localparam int DWB = 64;
`ifdef AHB_RSP_MUX_DEFSLV_EN
  localparam bit DEFSLV = 1'b1;
`else
  localparam bit DEFSLV = 1'b0;
`endif

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b1;
  logic [7:0] err_cnt_a;
  logic [1:0] err_cnt_b;

  always #5 HCLK = ~HCLK;

  ahb_rsp_mux_p_if #(.NSLV(NA), .DW(DWA)) if_a ();
  ahb_rsp_mux_p_if #(.NSLV(NB), .DW(DWB)) if_b ();

  ahb_rsp_mux_p #(.NSLV(NA), .DW(DWA), .ECW(8)) u_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if_a), .ERR_CNT(err_cnt_a));
  ahb_rsp_mux_p #(.NSLV(NB), .DW(DWB), .ECW(2)) u_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(if_b), .ERR_CNT(err_cnt_b));

  int n_pass = 0;
  int n_total = 0;

  // Reference model for DUT A: who owns the data phase, which beat of a
  // two-cycle ERROR response is showing (0 = none), and errors seen so far.
  int m_owner;
  int m_err;
  int m_cnt;

  typedef struct {
    logic [NA-1:0] hsel;
    logic [1:0]    htrans;
    logic [31:0]   rdata;
    logic          ready;
    logic [1:0]    resp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int lowest(input logic [NA-1:0] v);
    for (int i = 0; i < NA; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (m_owner >= 0) return if_a.HRDATA_S[m_owner*32 +: 32];
    return 32'h0;
  endfunction

  function automatic logic exp_ready();
    if (m_owner >= 0) return if_a.HREADY_S[m_owner];
    return (m_err == 1) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [1:0] exp_resp();
    if (m_owner >= 0) return if_a.HRESP_S[m_owner*2 +: 2];
    return (m_err != 0) ? 2'b01 : 2'b00;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_err   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    if (exp_ready()) begin
      m_owner = lowest(if_a.HSEL);
      if (DEFSLV && if_a.HSEL == '0 && if_a.HTRANS[1]) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end else begin
        m_err = 0;
      end
    end else if (m_err == 1) begin
      m_err = 2;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rdata"}, 64'(if_a.HRDATAm), 64'(exp_rdata()));
    chk({tag, "_ready"}, 64'(if_a.HREADYm), 64'(exp_ready()));
    chk({tag, "_resp"},  64'(if_a.HRESPm),  64'(exp_resp()));
    chk({tag, "_cnt"},   64'(err_cnt_a),    64'(m_cnt));
  endtask

  task automatic drive_a(input logic [NA-1:0] hsel, input logic [1:0] htrans);
    if_a.HSEL   = hsel;
    if_a.HTRANS = htrans;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    logic [31:0] d3;
    logic [31:0] d0;
    vecs[0] = '{5'b00100, 2'b10, 32'hDEADBEEF, 1'b1, 2'b00};
    vecs[1] = '{5'b10110, 2'b10, 32'h1000_0001, 1'b1, 2'b00};
    vecs[2] = '{5'b11000, 2'b11, 32'h1000_0003, 1'b1, 2'b00};
    vecs[3] = '{5'b00001, 2'b10, 32'h1000_0000, 1'b1, 2'b00};
    vecs[4] = '{5'b10000, 2'b10, 32'h1000_0004, 1'b1, 2'b01};
    vecs[5] = '{5'b00000, 2'b00, 32'h0,         1'b1, 2'b00};
    vecs[6] = '{5'b11111, 2'b01, 32'h1000_0000, 1'b1, 2'b00};

    drive_a('0, 2'b00);
    if_a.HREADY_S = '1;
    if_a.HRESP_S  = '0;
    for (int i = 0; i < NA; i++) if_a.HRDATA_S[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    if_a.HRDATA_S[2*32 +: 32] = 32'hDEADBEEF;
    if_a.HRESP_S[4*2 +: 2] = 2'b01;
    if_b.HSEL     = '0;
    if_b.HTRANS   = 2'b00;
    if_b.HREADY_S = '1;
    if_b.HRESP_S  = '0;
    for (int i = 0; i < NB; i++) if_b.HRDATA_S[i*64 +: 64] = 64'(i);
    if_b.HRDATA_S[15*64 +: 64] = 64'hFEDC_BA98_7654_3210;
    model_reset();

    // Asynchronous reset: visible before any clock edge.
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_ready", 64'(if_a.HREADYm), 64'd1);
    chk("rst_resp",  64'(if_a.HRESPm),  64'd0);
    chk("rst_rdata", 64'(if_a.HRDATAm), 64'd0);
    chk("rst_cnt",   64'(err_cnt_a),    64'd0);
    chk("rst_b_cnt", 64'(err_cnt_b),    64'd0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Vector table: one address phase, then the data phase it produces.
    for (int v = 0; v < 7; v++) begin
      drive_a(vecs[v].hsel, vecs[v].htrans);
      tick();
      drive_a('0, 2'b00);
      #1;
      chk($sformatf("vec%0d_rdata", v), 64'(if_a.HRDATAm), 64'(vecs[v].rdata));
      chk($sformatf("vec%0d_ready", v), 64'(if_a.HREADYm), 64'(vecs[v].ready));
      chk($sformatf("vec%0d_resp", v),  64'(if_a.HRESPm),  64'(vecs[v].resp));
    end

    // Slave 3 stalls for three cycles while the decoder already selects slave 0.
    d3 = if_a.HRDATA_S[3*32 +: 32];
    d0 = if_a.HRDATA_S[0*32 +: 32];
    drive_a(5'b01000, 2'b10);
    tick();
    drive_a(5'b00001, 2'b10);
    if_a.HREADY_S[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), 64'(if_a.HREADYm), 64'd0);
      if (c < 2) tick();
    end
    if_a.HREADY_S[3] = 1'b1;
    #1;
    chk("stall_end_rdata", 64'(if_a.HRDATAm), 64'(d3));
    chk("stall_end_ready", 64'(if_a.HREADYm), 64'd1);
    tick();
    drive_a('0, 2'b00);
    #1;
    chk("after_stall_rdata", 64'(if_a.HRDATAm), 64'(d0));

    // Two back-to-back unmapped transfers, then IDLE.
    do_reset();
    drive_a('0, 2'b10);
    tick();
    chk("um_e1_ready", 64'(if_a.HREADYm), DEFSLV ? 64'd0 : 64'd1);
    chk("um_e1_resp",  64'(if_a.HRESPm),  DEFSLV ? 64'd1 : 64'd0);
    chk("um_e1_cnt",   64'(err_cnt_a),    DEFSLV ? 64'd1 : 64'd0);
    tick();
    chk("um_e2_ready", 64'(if_a.HREADYm), 64'd1);
    chk("um_e2_resp",  64'(if_a.HRESPm),  DEFSLV ? 64'd1 : 64'd0);
    tick();
    drive_a('0, 2'b00);
    #1;
    chk("um_e3_ready", 64'(if_a.HREADYm), DEFSLV ? 64'd0 : 64'd1);
    chk("um_e3_resp",  64'(if_a.HRESPm),  DEFSLV ? 64'd1 : 64'd0);
    chk("um_e3_cnt",   64'(err_cnt_a),    DEFSLV ? 64'd2 : 64'd0);
    tick();
    chk("um_e4_ready", 64'(if_a.HREADYm), 64'd1);
    chk("um_e4_resp",  64'(if_a.HRESPm),  DEFSLV ? 64'd1 : 64'd0);
    tick();
    chk("um_idle_ready", 64'(if_a.HREADYm), 64'd1);
    chk("um_idle_resp",  64'(if_a.HRESPm),  64'd0);
    chk("um_idle_rdata", 64'(if_a.HRDATAm), 64'd0);
    chk("um_idle_cnt",   64'(err_cnt_a),    DEFSLV ? 64'd2 : 64'd0);

    // Reset pulsed in the first ERROR beat aborts it immediately.
    drive_a('0, 2'b10);
    tick();
    chk("rerr_pre_ready", 64'(if_a.HREADYm), DEFSLV ? 64'd0 : 64'd1);
    HRESETn = 1'b0;
    #1;
    chk("rerr_ready", 64'(if_a.HREADYm), 64'd1);
    chk("rerr_resp",  64'(if_a.HRESPm),  64'd0);
    chk("rerr_rdata", 64'(if_a.HRDATAm), 64'd0);
    chk("rerr_cnt",   64'(err_cnt_a),    64'd0);
    model_reset();
    drive_a('0, 2'b00);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    #1;
    chk("rerr_post_ready", 64'(if_a.HREADYm), 64'd1);

    // Reset pulsed during a slave stall.
    drive_a(5'b01000, 2'b10);
    if_a.HREADY_S[3] = 1'b0;
    tick();
    chk("rstall_pre_ready", 64'(if_a.HREADYm), 64'd0);
    HRESETn = 1'b0;
    #1;
    chk("rstall_ready", 64'(if_a.HREADYm), 64'd1);
    chk("rstall_rdata", 64'(if_a.HRDATAm), 64'd0);
    model_reset();
    if_a.HREADY_S[3] = 1'b1;
    drive_a('0, 2'b00);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Wide instance: ECW=2 saturation over five unmapped transfers, then 64-bit data from slave 15.
    if_b.HSEL   = '0;
    if_b.HTRANS = 2'b10;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 4) chk("b_cnt_mid", 64'(err_cnt_b), DEFSLV ? 64'd2 : 64'd0);
    end
    chk("b_cnt_sat", 64'(err_cnt_b), DEFSLV ? 64'd3 : 64'd0);
    chk("b_err2_ready", 64'(if_b.HREADYm), 64'd1);
    if_b.HSEL   = 16'h8000;
    if_b.HTRANS = 2'b10;
    tick();
    if_b.HSEL   = '0;
    if_b.HTRANS = 2'b00;
    #1;
    chk("b_s15_rdata", if_b.HRDATAm, 64'hFEDC_BA98_7654_3210);
    chk("b_s15_ready", 64'(if_b.HREADYm), 64'd1);
    chk("b_s15_resp",  64'(if_b.HRESPm),  64'd0);
    chk("b_cnt_hold",  64'(err_cnt_b), DEFSLV ? 64'd3 : 64'd0);

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) if_a.HSEL = '0;
      else if_a.HSEL = NA'($urandom);
      if_a.HTRANS   = 2'($urandom);
      if_a.HREADY_S = NA'($urandom | $urandom);
      if_a.HRESP_S  = (2*NA)'($urandom);
      for (int i = 0; i < NA; i++) if_a.HRDATA_S[i*32 +: 32] = $urandom;
      #1;
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
